// File: rtl/psum_collector_if.sv
// rtl/psum_collector_if.sv - psum input / result output stream bundle
// Purpose: groups the PE psum-triple input stream and the per-lane result
//          output stream of psum_collector.
// Signals:
//   in_valid, in_ready      input triple handshake
//   in_psum0..2   [2N]      lane psums, unsigned
//   out_valid, out_ready    result beat handshake
//   out_data      [ACC_W]   lane result, unsigned
//   out_lane      [2]       lane index of out_data
// Modports: slave = collector side, master = PE/writer side.
interface psum_collector_if #(
  parameter int N     = 8,
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [2*N-1:0]   in_psum0;
  logic [2*N-1:0]   in_psum1;
  logic [2*N-1:0]   in_psum2;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic [1:0]       out_lane;

  modport slave (
    input  in_valid, in_psum0, in_psum1, in_psum2, out_ready,
    output in_ready, out_valid, out_data, out_lane
  );

  modport master (
    output in_valid, in_psum0, in_psum1, in_psum2, out_ready,
    input  in_ready, out_valid, out_data, out_lane
  );
endinterface

// File: rtl/psum_collector.sv
// rtl/psum_collector.sv - accumulate PE psum triples over CH channels, stream row results
// Purpose: accumulates the three lane psums of the PE over CH input channels,
//          queues finished rows (3 lane results) in a DEPTH-entry FIFO and sends
//          them one lane per beat on a registered valid/ready stream.
// Ports:
//   clk     in   clock, rising edge
//   reset   in   async active-high reset, clears all state
//   clear   in   sync, drops the partial accumulation (ch_cnt -> 0)
//   s       --   psum_collector_if.slave (input triples, output beats)
//   ch_cnt  out  channels accepted for the current row
//   busy    out  ch_cnt != 0 or FIFO not empty
// Configuration: define PSUM_SAT_EN to clamp out_data to 2^(2N)-1; the FIFO
//                always holds the full ACC_W result.
module psum_collector #(
  parameter int N     = 8,
  parameter int CH    = 4,
  parameter int ACC_W = 20,
  parameter int DEPTH = 4,
  localparam int CNT_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  psum_collector_if.slave  s,
  output logic [CNT_W-1:0] ch_cnt,
  output logic             busy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CH = CNT_W'(CH - 1);
  localparam logic [ACC_W-1:0] SAT_MAX = {{(ACC_W-2*N){1'b0}}, {(2*N){1'b1}}};

  typedef logic [ACC_W-1:0]   acc_t;
  typedef logic [3*ACC_W-1:0] row_t;
  typedef enum logic {IDLE, SEND} state_t;

  acc_t           acc [3];
  acc_t           sum [3];
  logic [2*N-1:0] psum_in [3];
  row_t           mem [DEPTH];
  row_t           push_data;
  row_t           head;
  row_t           next_entry;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           fifo_full;
  logic           fifo_empty;
  logic           accept;
  logic           last_ch;
  logic           push;
  logic           pop;
  logic           have_next;

  state_t         state;
  state_t         state_n;
  logic           out_valid_n;
  acc_t           out_data_n;
  logic [1:0]     out_lane_n;

  function automatic acc_t lane_sel(input row_t e, input logic [1:0] l);
    case (l)
      2'd0:    return e[ACC_W-1:0];
      2'd1:    return e[2*ACC_W-1:ACC_W];
      default: return e[3*ACC_W-1:2*ACC_W];
    endcase
  endfunction

  function automatic acc_t sat(input acc_t v);
`ifdef PSUM_SAT_EN
    return (v > SAT_MAX) ? SAT_MAX : v;
`else
    return v;
`endif
  endfunction

  assign psum_in[0] = s.in_psum0;
  assign psum_in[1] = s.in_psum1;
  assign psum_in[2] = s.in_psum2;

  assign fifo_full  = (count == (AW+1)'(DEPTH));
  assign fifo_empty = (count == '0);
  // in_ready looks at full only; a pop in the same cycle does not free a slot early.
  assign s.in_ready = !fifo_full && !reset;
  assign accept     = s.in_valid && s.in_ready && !clear;
  assign last_ch    = (ch_cnt == LAST_CH);
  assign push       = accept && last_ch;
  assign busy       = (ch_cnt != '0) || !fifo_empty;

  // First channel of a row starts from zero instead of the stale accumulator.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      sum[k] = ((ch_cnt == '0) ? '0 : acc[k]) + ACC_W'(psum_in[k]);
    end
  end

  assign push_data = {sum[2], sum[1], sum[0]};
  assign head      = mem[rd_ptr];
  // The entry that follows the head may be the one being written this very edge.
  assign have_next  = (count > (AW+1)'(1)) || push;
  assign next_entry = (count > (AW+1)'(1)) ? mem[rd_ptr + AW'(1)] : push_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_cnt <= '0;
      for (int k = 0; k < 3; k++) acc[k] <= '0;
    end else if (clear) begin
      ch_cnt <= '0;
    end else if (accept) begin
      for (int k = 0; k < 3; k++) acc[k] <= sum[k];
      ch_cnt <= last_ch ? '0 : ch_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      s.out_valid <= 1'b0;
      s.out_data  <= '0;
      s.out_lane  <= 2'd0;
    end else begin
      state       <= state_n;
      s.out_valid <= out_valid_n;
      s.out_data  <= out_data_n;
      s.out_lane  <= out_lane_n;
    end
  end

  always_comb begin
    state_n     = state;
    out_valid_n = s.out_valid;
    out_data_n  = s.out_data;
    out_lane_n  = s.out_lane;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_n     = SEND;
          out_valid_n = 1'b1;
          out_lane_n  = 2'd0;
          out_data_n  = sat(lane_sel(head, 2'd0));
        end
      end
      SEND: begin
        if (s.out_valid && s.out_ready) begin
          if (s.out_lane != 2'd2) begin
            out_lane_n = s.out_lane + 2'd1;
            out_data_n = sat(lane_sel(head, s.out_lane + 2'd1));
          end else begin
            // Lane 2 done: retire the head and chain straight into the next row.
            pop = 1'b1;
            if (have_next) begin
              out_lane_n = 2'd0;
              out_data_n = sat(lane_sel(next_entry, 2'd0));
            end else begin
              state_n     = IDLE;
              out_valid_n = 1'b0;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_psum_collector.sv
// tb/tb_psum_collector.sv - randomized self-checking bench for psum_collector
module tb_psum_collector;
  localparam int N     = 8;
  localparam int CH    = 4;
  localparam int ACC_W = 20;
  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             clear;
  logic [CNT_W-1:0] ch_cnt;
  logic             busy;

  psum_collector_if #(.N(N), .ACC_W(ACC_W)) bus ();

  psum_collector #(.N(N), .CH(CH), .ACC_W(ACC_W), .DEPTH(DEPTH)) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .s      (bus.slave),
    .ch_cnt (ch_cnt),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference model: a row is the per-lane sum of CH accepted triples; each
  // finished row adds three beats (lane 0,1,2) to the expected stream.
  int unsigned m_sum [3];
  int          m_ch = 0;
  int unsigned expq_data [$];
  int unsigned expq_lane [$];
  int          beats = 0;
  bit          prev_hold = 0;
  logic [ACC_W-1:0] prev_data;
  logic [1:0]  prev_lane;
  bit          toggle_en = 0;

  function automatic int unsigned expect_val(input int unsigned v);
`ifdef PSUM_SAT_EN
    return (v > 65535) ? 65535 : v;
`else
    return v;
`endif
  endfunction

  // Monitor samples 2 time units before each rising edge.
  always begin
    @(negedge clk);
    #3;
    if (reset) begin
      expq_data.delete();
      expq_lane.delete();
      m_ch      = 0;
      prev_hold = 0;
    end else begin
      chk("ch_cnt", 32'(ch_cnt), 32'(m_ch));
      chk("busy", 32'(busy), 32'((m_ch != 0) || (expq_data.size() != 0)));
      chk("in_ready", 32'(bus.in_ready), 32'(((expq_data.size() + 2) / 3) < DEPTH));
      if (prev_hold) begin
        chk("hold_data", 32'(bus.out_data), 32'(prev_data));
        chk("hold_lane", 32'(bus.out_lane), 32'(prev_lane));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq_data.size() == 0) begin
          chk("spurious_beat", 32'(bus.out_data), 32'hFFFF_FFFF);
        end else begin
          chk("beat_data", 32'(bus.out_data), expq_data.pop_front());
          chk("beat_lane", 32'(bus.out_lane), expq_lane.pop_front());
        end
        beats++;
      end
      prev_hold = bus.out_valid && !bus.out_ready;
      prev_data = bus.out_data;
      prev_lane = bus.out_lane;
      if (clear) begin
        m_ch = 0;
      end else if (bus.in_valid && bus.in_ready) begin
        m_sum[0] = ((m_ch == 0) ? 0 : m_sum[0]) + bus.in_psum0;
        m_sum[1] = ((m_ch == 0) ? 0 : m_sum[1]) + bus.in_psum1;
        m_sum[2] = ((m_ch == 0) ? 0 : m_sum[2]) + bus.in_psum2;
        m_ch++;
        if (m_ch == CH) begin
          m_ch = 0;
          for (int k = 0; k < 3; k++) begin
            expq_data.push_back(expect_val(m_sum[k]));
            expq_lane.push_back(k);
          end
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (toggle_en) bus.out_ready = ~bus.out_ready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input int unsigned a, input int unsigned b, input int unsigned c);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.in_psum0 = 16'(a);
    bus.in_psum1 = 16'(b);
    bus.in_psum2 = 16'(c);
    for (int i = 0; i < 200 && !done; i++) begin
      done = bus.in_ready;
      step();
    end
    bus.in_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic push_rand();
    push($urandom_range(0, 65535), $urandom_range(0, 65535), $urandom_range(0, 65535));
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.out_valid) seen = 1;
      else step();
    end
    if (!seen) chk("valid_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    bit done;
    done = 0;
    for (int i = 0; i < 500 && !done; i++) begin
      if (expq_data.size() == 0 && !bus.out_valid) done = 1;
      else step();
    end
    if (!done) chk("drain_timeout", 32'(expq_data.size()), 0);
  endtask

  initial begin
    int b0;
    logic [ACC_W-1:0] d;
    bus.in_valid  = 1'b0;
    bus.in_psum0  = '0;
    bus.in_psum1  = '0;
    bus.in_psum2  = '0;
    bus.out_ready = 1'b1;
    clear = 1'b0;
    reset = 1'b1;
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_data", 32'(bus.out_data), 0);
    chk("rst_out_lane", 32'(bus.out_lane), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ch_cnt", 32'(ch_cnt), 0);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus.in_ready), 1);
    step();

    // 1: basic row and output latency
    for (int i = 0; i < 4; i++) push(1, 2, 3);
    chk("t1_lat_before", 32'(bus.out_valid), 0);
    step();
    chk("t1_lat_valid", 32'(bus.out_valid), 1);
    chk("t1_data0", 32'(bus.out_data), 4);
    chk("t1_lane0", 32'(bus.out_lane), 0);
    wait_drain();

    // 2: full-scale inputs
    for (int i = 0; i < 4; i++) push(65535, 65535, 65535);
    wait_valid();
`ifdef PSUM_SAT_EN
    chk("t2_max", 32'(bus.out_data), 65535);
`else
    chk("t2_max", 32'(bus.out_data), 262140);
`endif
    wait_drain();

    // 3: back-pressure until the FIFO fills
    bus.out_ready = 1'b0;
    b0 = beats;
    for (int i = 0; i < 16; i++) push_rand();
    chk("t3_full_in_ready", 32'(bus.in_ready), 0);
    d = bus.out_data;
    repeat (5) step();
    chk("t3_hold_valid", 32'(bus.out_valid), 1);
    chk("t3_hold_data", 32'(bus.out_data), 32'(d));
    bus.out_ready = 1'b1;
    wait_drain();
    chk("t3_beats", 32'(beats - b0), 12);

    // 4: clear drops a partial row and wins over in_valid
    push(5, 5, 5);
    push(5, 5, 5);
    clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_psum0 = 16'd7;
    bus.in_psum1 = 16'd7;
    bus.in_psum2 = 16'd7;
    chk("t4_clear_in_ready", 32'(bus.in_ready), 1);
    step();
    clear = 1'b0;
    bus.in_valid = 1'b0;
    chk("t4_clear_ch_cnt", 32'(ch_cnt), 0);
    for (int i = 0; i < 4; i++) push(1, 1, 1);
    wait_valid();
    chk("t4_data", 32'(bus.out_data), 4);
    wait_drain();

    // 5: reset during the lane-1 beat with a partial row pending
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(2, 2, 2);
    wait_valid();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("t5_lane1", 32'(bus.out_lane), 1);
    push(9, 9, 9);
    push(9, 9, 9);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(bus.out_valid), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_ch_cnt", 32'(ch_cnt), 0);
    chk("t5_rst_data", 32'(bus.out_data), 0);
    step();
    reset = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(3, 3, 3);
    wait_valid();
    chk("t5_after_data", 32'(bus.out_data), 12);
    chk("t5_after_lane", 32'(bus.out_lane), 0);
    wait_drain();

    // 6: out_ready toggling every cycle over three rows
    b0 = beats;
    toggle_en = 1;
    for (int i = 0; i < 12; i++) push_rand();
    wait_drain();
    toggle_en = 0;
    step();
    bus.out_ready = 1'b1;
    chk("t6_beats", 32'(beats - b0), 9);

    // 7: free-running random traffic with occasional clear
    for (int i = 0; i < 400; i++) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_psum0  = 16'($urandom_range(0, 65535));
      bus.in_psum1  = 16'($urandom_range(0, 65535));
      bus.in_psum2  = 16'($urandom_range(0, 65535));
      clear         = ($urandom_range(0, 19) == 0);
      step();
    end
    clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
